// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing types and the standard mode constant sets.
// Mode records feed the parameter defaults of vga_timing_gen.
package vga_timing_gen_pkg;

    typedef struct packed {
        int   h_disp;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_disp;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_pol;
        logic v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_1280X1024_60 = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};
    localparam vga_mode_t MODE_640X480_60   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam vga_mode_t MODE_800X600_60   = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};

    // Request-time control bits carried down the output pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } vga_ctl_t;

    localparam int CTL_W = $bits(vga_ctl_t);

    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH enabled shift register with asynchronous active-low clear.
// DOUT is DIN delayed by DEPTH enabled clocks.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                stages <= '0;
            end else if (EN) begin
                stages <= DIN;
            end
        end
    end else begin : g_multi
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                stages <= '0;
            end else if (EN) begin
                stages <= {stages[DEPTH-2:0], DIN};
            end
        end
    end

    assign DOUT = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with look-ahead pixel request,
// LEAD-cycle control pipeline and registered RGB output stage.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_DISP  = MODE_1280X1024_60.h_disp,
    parameter int   H_FRONT = MODE_1280X1024_60.h_front,
    parameter int   H_SYNC  = MODE_1280X1024_60.h_sync,
    parameter int   H_BACK  = MODE_1280X1024_60.h_back,
    parameter int   V_DISP  = MODE_1280X1024_60.v_disp,
    parameter int   V_FRONT = MODE_1280X1024_60.v_front,
    parameter int   V_SYNC  = MODE_1280X1024_60.v_sync,
    parameter int   V_BACK  = MODE_1280X1024_60.v_back,
    parameter logic H_POL   = MODE_1280X1024_60.h_pol,
    parameter logic V_POL   = MODE_1280X1024_60.v_pol,
    parameter int   CW      = 4,
    parameter int   LEAD    = 2,
    parameter int   CNT_W   = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [3*CW-1:0]   RGB_IN,
    output logic              REQ,
    output logic [CNT_W-1:0]  REQ_X,
    output logic [CNT_W-1:0]  REQ_Y,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic              VGA_DE,
    output logic [CW-1:0]     VGA_RED,
    output logic [CW-1:0]     VGA_GREEN,
    output logic [CW-1:0]     VGA_BLUE,
    output logic              FRAME_START,
    output logic              LINE_START
);

    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (LEAD < 1 || LEAD > 4) begin : g_bad_lead
        $error("vga_timing_gen: LEAD must lie within 1..4");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    logic             run;
    logic             adv;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    int               hpos;
    int               vpos;
    vga_ctl_t         raw;
    vga_ctl_t         pre_ctl;
    vga_ctl_t         out_ctl;
    logic [3*CW-1:0]  rgb_q;

    // run holds the raster at (0,0) until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign adv = EN & run;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (adv) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    always_comb begin
        hpos   = 32'(hcnt);
        vpos   = 32'(vcnt);
        raw    = '0;
        raw.de = (hpos < H_DISP) && (vpos < V_DISP);
        raw.hs = in_window(hpos, H_DISP + H_FRONT, H_SYNC);
        raw.vs = in_window(vpos, V_DISP + V_FRONT, V_SYNC);
        raw.fs = (hcnt == '0) && (vcnt == '0);
        raw.ls = (hcnt == '0) && (vpos < V_DISP);
    end

    assign REQ   = raw.de & EN & run;
    assign REQ_X = REQ ? hcnt : '0;
    assign REQ_Y = REQ ? vcnt : '0;

    // Pipeline split so the stage gating the RGB capture is a real tap.
    if (LEAD == 1) begin : g_pre_raw
        assign pre_ctl = raw;
    end else begin : g_pre_dly
        vga_delay_line #(
            .WIDTH (CTL_W),
            .DEPTH (LEAD - 1)
        ) u_pre_dly (
            .CLK   (CLK),
            .RST_N (RST_N),
            .EN    (adv),
            .DIN   (raw),
            .DOUT  (pre_ctl)
        );
    end

    vga_delay_line #(
        .WIDTH (CTL_W),
        .DEPTH (1)
    ) u_out_dly (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (adv),
        .DIN   (pre_ctl),
        .DOUT  (out_ctl)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rgb_q <= '0;
        end else if (adv) begin
            rgb_q <= pre_ctl.de ? RGB_IN : '0;
        end
    end

    assign VGA_HSYNC   = out_ctl.hs ? H_POL : ~H_POL;
    assign VGA_VSYNC   = out_ctl.vs ? V_POL : ~V_POL;
    assign VGA_DE      = out_ctl.de;
    assign FRAME_START = out_ctl.fs;
    assign LINE_START  = out_ctl.ls;
    assign VGA_RED     = rgb_q[3*CW-1 -: CW];
    assign VGA_GREEN   = rgb_q[2*CW-1 -: CW];
    assign VGA_BLUE    = rgb_q[CW-1:0];

endmodule
